// File: rtl/otter_io_pkg.sv
// otter_io_pkg
// Shared constants for the OTTER I/O output demultiplexer: port count,
// register-window geometry, STATUS field positions and a helper that
// packs the per-port flags into the 32-bit STATUS word.
package otter_io_pkg;

    localparam int          DATA_W     = 32;
    localparam int          NUM_PORTS  = 4;
    localparam int          IDX_W      = 3;
    localparam logic [2:0]  STATUS_IDX = 3'd4;
    localparam int          WINDOW_LSB = 5;

    // STATUS layout: {24'b0, OVR[3:0], PEND[3:0]}
    localparam int          PEND_LSB   = 0;
    localparam int          OVR_LSB    = 4;
    localparam int          FLAG_W     = NUM_PORTS;

    function automatic logic [DATA_W-1:0] build_status(
        input logic [FLAG_W-1:0] ovr,
        input logic [FLAG_W-1:0] pend
    );
        logic [DATA_W-1:0] s;
        s = '0;
        s[PEND_LSB +: FLAG_W] = pend;
        s[OVR_LSB  +: FLAG_W] = ovr;
        return s;
    endfunction

endpackage

// File: rtl/io_port_reg.sv
// io_port_reg
// State for one output port of the I/O demultiplexer.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : accepted data write to this port this cycle
//   wr_data    : store data for the write
//   ack        : peripheral acknowledge, consumes the pending value
//   ovr_clr    : software clear of the sticky overrun flag
//   data       : registered port data
//   stb        : one-cycle pulse following each accepted write
//   pend       : data written but not yet acknowledged
//   ovr        : sticky overrun (written while still pending, no ack)
module io_port_reg
    import otter_io_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ack,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] data,
    output logic              stb,
    output logic              pend,
    output logic              ovr
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              stb_q,  stb_d;
    logic              pend_q, pend_d;
    logic              ovr_q,  ovr_d;

    always_comb begin
        data_d = data_q;
        stb_d  = wr_en;
        pend_d = pend_q;
        ovr_d  = ovr_q;

        if (wr_en) begin
            data_d = wr_data;
            // A simultaneous ack consumes the old value, so the new one is
            // still pending and nothing was lost.
            pend_d = 1'b1;
            if (pend_q && !ack) begin
                ovr_d = 1'b1;
            end
        end else begin
            if (ack) begin
                pend_d = 1'b0;
            end
            // A write and a status clear never coincide (one address per
            // cycle), so the set above naturally takes priority.
            if (ovr_clr) begin
                ovr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VAL;
            stb_q  <= 1'b0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            stb_q  <= stb_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign data = data_q;
    assign stb  = stb_q;
    assign pend = pend_q;
    assign ovr  = ovr_q;

endmodule

// File: rtl/otter_io_demux.sv
// otter_io_demux
// Memory-mapped output demultiplexer on the OTTER I/O bus. Decodes CPU
// stores inside a 32-byte window at BASE_ADDR into four registered output
// ports (word offsets 0x00-0x0C) and a STATUS register (offset 0x10,
// write-1-to-clear on the overrun bits [7:4]).
//   CLK, RST             : clock, asynchronous active-high reset
//   IOBUS_ADDR/OUT/WR    : CPU store address, data and qualifier
//   PORT_ACK[3:0]        : per-port peripheral acknowledge
//   PORT0..3_DATA        : registered port data
//   PORT_STB[3:0]        : one-cycle pulse per accepted data write
//   PORT_PEND[3:0]       : data not yet acknowledged
//   PORT_OVR[3:0]        : sticky overrun flags
//   STATUS               : {24'b0, PORT_OVR, PORT_PEND}
module otter_io_demux
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    input  logic [NUM_PORTS-1:0] PORT_ACK,
    output logic [31:0]          PORT0_DATA,
    output logic [31:0]          PORT1_DATA,
    output logic [31:0]          PORT2_DATA,
    output logic [31:0]          PORT3_DATA,
    output logic [NUM_PORTS-1:0] PORT_STB,
    output logic [NUM_PORTS-1:0] PORT_PEND,
    output logic [NUM_PORTS-1:0] PORT_OVR,
    output logic [31:0]          STATUS
);

    logic                 hit;
    logic [IDX_W-1:0]     idx;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] ovr_clr;
    logic [DATA_W-1:0]    port_data [NUM_PORTS];

    // Word-aligned store that lands inside the 32-byte window.
    assign hit = IOBUS_WR
              && (IOBUS_ADDR[31:WINDOW_LSB] == BASE_ADDR[31:WINDOW_LSB])
              && (IOBUS_ADDR[1:0] == 2'b00);
    assign idx = IOBUS_ADDR[WINDOW_LSB-1:2];

    assign ovr_clr = (hit && (idx == STATUS_IDX)) ? IOBUS_OUT[OVR_LSB +: FLAG_W]
                                                  : '0;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign wr_en[i] = hit && (idx == IDX_W'(i));

        io_port_reg #(
            .RESET_VAL (RESET_VAL)
        ) u_port (
            .clk     (CLK),
            .rst     (RST),
            .wr_en   (wr_en[i]),
            .wr_data (IOBUS_OUT),
            .ack     (PORT_ACK[i]),
            .ovr_clr (ovr_clr[i]),
            .data    (port_data[i]),
            .stb     (PORT_STB[i]),
            .pend    (PORT_PEND[i]),
            .ovr     (PORT_OVR[i])
        );
    end

    assign PORT0_DATA = port_data[0];
    assign PORT1_DATA = port_data[1];
    assign PORT2_DATA = port_data[2];
    assign PORT3_DATA = port_data[3];

    assign STATUS = build_status(PORT_OVR, PORT_PEND);

endmodule

// File: tb/tb_otter_io_demux.sv
module tb_otter_io_demux;

    localparam logic [31:0] BASE = 32'h1100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] dout = '0;
    logic        wr = 1'b0;
    logic [3:0]  ack = '0;
    logic [31:0] p0, p1, p2, p3, status;
    logic [3:0]  stb, pend, ovr;

    int checks = 0;
    int errors = 0;

    otter_io_demux #(
        .BASE_ADDR (BASE),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .IOBUS_ADDR (addr),
        .IOBUS_OUT  (dout),
        .IOBUS_WR   (wr),
        .PORT_ACK   (ack),
        .PORT0_DATA (p0),
        .PORT1_DATA (p1),
        .PORT2_DATA (p2),
        .PORT3_DATA (p3),
        .PORT_STB   (stb),
        .PORT_PEND  (pend),
        .PORT_OVR   (ovr),
        .STATUS     (status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][31:0] d;
        logic [3:0]       stb;
        logic [3:0]       pend;
        logic [3:0]       ovr;
    } exp_t;

    exp_t sb[$];

    // Reference state: what each port should hold according to the rules.
    logic [31:0] m_data [4];
    logic [3:0]  m_pend;
    logic [3:0]  m_ovr;
    logic [3:0]  m_stb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_data[i] = 32'h0;
        m_pend = '0;
        m_ovr  = '0;
        m_stb  = '0;
    endtask

    // Apply the register-map rules to the current bus inputs.
    task automatic model_edge();
        bit       in_window;
        int       word;
        exp_t     e;
        in_window = wr && ((addr - BASE) < 32'd32) && (addr >= BASE) && (addr % 4 == 0);
        word = int'((addr - BASE) / 4);
        m_stb = '0;
        for (int i = 0; i < 4; i++) begin
            if (in_window && word == i) begin
                if (m_pend[i] && !ack[i]) m_ovr[i] = 1'b1;
                m_data[i] = dout;
                m_pend[i] = 1'b1;
                m_stb[i]  = 1'b1;
            end else if (ack[i]) begin
                m_pend[i] = 1'b0;
            end
        end
        if (in_window && word == 4) m_ovr = m_ovr & ~dout[7:4];
        for (int i = 0; i < 4; i++) e.d[i] = m_data[i];
        e.stb  = m_stb;
        e.pend = m_pend;
        e.ovr  = m_ovr;
        sb.push_back(e);
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] k);
        wr = w; addr = a; dout = d; ack = k;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Monitor: the DUT presents a new port state after every edge.
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("port0_data", p0, e.d[0]);
            chk("port1_data", p1, e.d[1]);
            chk("port2_data", p2, e.d[2]);
            chk("port3_data", p3, e.d[3]);
            chk("port_stb",  {28'b0, stb},  {28'b0, e.stb});
            chk("port_pend", {28'b0, pend}, {28'b0, e.pend});
            chk("port_ovr",  {28'b0, ovr},  {28'b0, e.ovr});
            chk("status", status, {24'b0, e.ovr, e.pend});
        end
    end

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      return BASE + {$urandom_range(0, 5), 2'b00};
        else if (r == 7) return BASE + $urandom_range(0, 31);
        else if (r == 8) return BASE + 32'd32 + {$urandom_range(0, 3), 2'b00};
        else             return $urandom;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_data0", p0, 32'h0);
        chk("reset_flags", {20'b0, stb, pend, ovr}, 32'h0);
        chk("reset_status", status, 32'h0);
        rst = 1'b0;

        // Single write to port 2, then ack it.
        step(1, 32'h1100_0008, 32'hDEAD_BEEF, 4'b0000);
        chk("dbeef_data", p2, 32'hDEAD_BEEF);
        chk("dbeef_stb", {28'b0, stb}, 32'h4);
        step(0, 32'h0, 32'h0, 4'b0100);
        chk("ack_pend", {28'b0, pend}, 32'h0);

        // Back-to-back writes to port 0 without ack -> overrun.
        step(1, 32'h1100_0000, 32'd1, 4'b0000);
        step(1, 32'h1100_0000, 32'd2, 4'b0000);
        chk("ovr0_status", status, 32'h0000_0011);

        // Write with simultaneous ack: no overrun.
        step(1, 32'h1100_0004, 32'hA5A5_0001, 4'b0000);
        step(1, 32'h1100_0004, 32'hA5A5_0002, 4'b0010);
        chk("wr_ack_ovr1", {28'b0, ovr}, 32'h1);
        step(1, 32'h1100_0004, 32'hA5A5_0003, 4'b0000);

        // Status W1C on OVR[0] only.
        step(1, 32'h1100_0010, 32'h0000_0010, 4'b0000);
        chk("w1c_ovr", {28'b0, ovr}, 32'h2);

        // Ignored accesses.
        step(1, 32'h1100_0014, 32'hFFFF_FFFF, 4'b0000);
        step(1, 32'h1100_0002, 32'hFFFF_FFFF, 4'b0000);
        step(1, 32'h1100_0020, 32'hFFFF_FFFF, 4'b0000);
        step(0, 32'h1100_0000, 32'hFFFF_FFFF, 4'b0000);
        chk("ignored_p0", p0, 32'd2);

        // Asynchronous reset mid-write, between clock edges.
        step(1, 32'h1100_000C, 32'h1234_5678, 4'b0000);
        @(negedge clk);
        #2;
        wr = 1'b1; addr = 32'h1100_000C; dout = 32'hCAFE_F00D;
        rst = 1'b1;
        #1;
        chk("async_rst_p3", p3, 32'h0);
        chk("async_rst_p1", p1, 32'h0);
        chk("async_rst_flags", {20'b0, stb, pend, ovr}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        rst = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), rand_addr(), $urandom,
                 4'($urandom & $urandom));
        end
        step(0, 32'h0, 32'h0, 4'b0000);

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
